// File: rtl/vram_pkg.sv
// Shared types for the video-memory arbiter: slot owner encoding and host write payload.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 14;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_DISP,
        SLOT_WR,
        SLOT_RD
    } vram_slot_t;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic                   data;
    } vram_wr_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Host write FIFO for the video-memory arbiter; power-of-two depth, pointers wrap naturally.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  vram_wr_t               push_entry,
    input  logic                   pop,
    output vram_wr_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    vram_wr_t         store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; it is only read while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_entry;
        end
    end

    assign head  = store[rd_ptr];
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video memory arbiter: display scan-out owns active cycles, host writes/reads use blanking.
// Optional host read port is enabled by defining VRAM_ARB_RDPORT_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W      = VRAM_ADDR_W,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
`ifdef VRAM_ARB_RDPORT_EN
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_data,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata
);

    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH) + 1;

    vram_slot_t       slot;
    vram_wr_t         fifo_in;
    vram_wr_t         fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             disp_q;

`ifdef VRAM_ARB_RDPORT_EN
    logic              rd_pending;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_ret_q;
`endif

    assign fifo_in   = '{addr: VRAM_ADDR_W'(wr_addr), data: wr_data};
    assign wr_ready  = !rst && (fifo_count < CNT_W'(WFIFO_DEPTH));
    assign fifo_push = wr_valid && wr_ready;
    assign fifo_pop  = (slot == SLOT_WR);

    vram_wr_fifo #(
        .DEPTH (WFIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (vga_clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // A full FIFO must never advertise space
    fifo_full_blocks_push: assert property (@(posedge vga_clk) disable iff (rst) fifo_full |-> !wr_ready);

    // Slot owner, fixed priority; nothing touches memory while reset is asserted
    always_comb begin
        slot = SLOT_NONE;
        if (rst) begin
            slot = SLOT_NONE;
        end else if (disp_active) begin
            slot = SLOT_DISP;
        end else if (!fifo_empty) begin
            slot = SLOT_WR;
        end
`ifdef VRAM_ARB_RDPORT_EN
        else if (rd_pending) begin
            slot = SLOT_RD;
        end
`endif
    end

    // Memory-side drive for the chosen slot; idle cycles park on the display address
    always_comb begin
        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        case (slot)
            SLOT_WR: begin
                mem_addr  = ADDR_W'(fifo_head.addr);
                mem_we    = 1'b1;
                mem_wdata = fifo_head.data;
            end
`ifdef VRAM_ARB_RDPORT_EN
            SLOT_RD: begin
                mem_addr = rd_addr_q;
            end
`endif
            default: begin
                mem_addr = disp_addr;
            end
        endcase
    end

    // Remembers whether the data now on mem_rdata belongs to a display fetch
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            disp_q <= 1'b0;
        end else begin
            disp_q <= (slot == SLOT_DISP);
        end
    end

    assign disp_data = disp_q & mem_rdata;

`ifdef VRAM_ARB_RDPORT_EN
    assign rd_ready = !rst && !rd_pending;

    // One-deep read slot and the return strobe one cycle after its grant
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_addr_q  <= '0;
            rd_ret_q   <= 1'b0;
        end else begin
            if (slot == SLOT_RD) begin
                rd_pending <= 1'b0;
            end else if (rd_req && rd_ready) begin
                rd_pending <= 1'b1;
                rd_addr_q  <= rd_addr;
            end
            rd_ret_q <= (slot == SLOT_RD);
        end
    end

    assign rd_valid = rd_ret_q;
    assign rd_data  = rd_ret_q & mem_rdata;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a synchronous-read memory model; read-port scenarios
// are included when VRAM_ARB_RDPORT_EN is defined.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int unsigned AW    = VRAM_ADDR_W;
    localparam int unsigned MEM_N = 1 << AW;

    logic          vga_clk;
    logic          rst;
    logic          disp_active;
    logic [AW-1:0] disp_addr;
    logic          disp_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          rd_req;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_wdata;
    logic          mem_rdata;

    logic     mem_model [MEM_N];
    logic     ref_mem   [MEM_N];
    vram_wr_t exp_wr_q [$];
    logic     exp_disp_q [$];
    logic     exp_rd_q [$];
    int       checks;
    int       errors;
    logic     prev_disp;
    logic [4:0] wpat;
    logic [7:0] dpat;

    vram_arbiter #(
        .ADDR_W      (AW),
        .WFIFO_DEPTH (4)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .disp_active (disp_active),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef VRAM_ARB_RDPORT_EN
        .rd_req      (rd_req),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
`endif
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

`ifndef VRAM_ARB_RDPORT_EN
    assign rd_ready = 1'b0;
    assign rd_valid = 1'b0;
    assign rd_data  = 1'b0;
`endif

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Synchronous-read, read-before-write single-port memory
    always @(posedge vga_clk) begin
        if (mem_we) begin
            mem_model[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_model[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drive_disp(input logic act, input logic [AW-1:0] a);
        disp_active = act;
        disp_addr   = a;
        if (act && !rst) begin
            exp_disp_q.push_back(ref_mem[a]);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic d, input logic track, output logic acc);
        vram_wr_t e;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        acc      = wr_ready;
        if (acc && track) begin
            e.addr = a;
            e.data = d;
            exp_wr_q.push_back(e);
            ref_mem[a] = d;
        end
    endtask

    // Output monitor: pops expectations as the DUT produces display pixels, writes and read returns
    always @(negedge vga_clk) begin
        vram_wr_t e;
        if (prev_disp) begin
            if (exp_disp_q.size() == 0) begin
                check("disp_underflow", 32'd1, 32'd0);
            end else begin
                check("disp_data", 32'(disp_data), 32'(exp_disp_q.pop_front()));
            end
        end else begin
            check("disp_idle", 32'(disp_data), 32'd0);
        end
        prev_disp = disp_active && !rst;

        if (mem_we) begin
            check("we_in_blank", 32'(disp_active), 32'd0);
            if (exp_wr_q.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check("we_addr", 32'(mem_addr), 32'(e.addr));
                check("we_data", 32'(mem_wdata), 32'(e.data));
            end
        end
`ifdef VRAM_ARB_RDPORT_EN
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) begin
                check("spurious_rd_valid", 32'd1, 32'd0);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
        end
`else
        if (!mem_we) begin
            check("addr_no_rd", 32'(mem_addr), 32'(disp_addr));
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic racc;
        checks      = 0;
        errors      = 0;
        prev_disp   = 1'b0;
        wpat        = 5'b01101;
        dpat        = 8'b0100_1101;
        rst         = 1'b1;
        disp_active = 1'b0;
        disp_addr   = '0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = 1'b0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        for (int i = 0; i < int'(MEM_N); i++) begin
            mem_model[i] <= 1'b0;
            ref_mem[i]    = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            mem_model[14'h2200 + i] <= dpat[i];
            ref_mem[14'h2200 + i]    = dpat[i];
        end

        // Reset state
        repeat (3) tick();
        @(negedge vga_clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_disp_data", 32'(disp_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge vga_clk);
        check("wr_ready_out_of_rst", 32'(wr_ready), 32'd1);
`ifdef VRAM_ARB_RDPORT_EN
        check("rd_ready_out_of_rst", 32'(rd_ready), 32'd1);
`endif

        // Display scan-out of a preloaded pattern
        for (int i = 0; i < 8; i++) begin
            tick();
            drive_disp(1'b1, 14'h2200 + 14'(i));
        end

        // Five writes during active display fill a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            tick();
            drive_disp(1'b1, 14'h2200 + 14'(i));
            host_write(14'h0100 + 14'(i), wpat[i], 1'b1, acc);
            check("wr_accept_fill", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
        end
        tick();
        wr_valid = 1'b0;
        drive_disp(1'b1, 14'h2205);
        @(negedge vga_clk);
        check("wr_ready_full_in_disp", 32'(wr_ready), 32'd0);
        check("no_we_in_disp", 32'(mem_we), 32'd0);
        tick();
        drive_disp(1'b0, '0);
        for (int j = 0; j < 4; j++) begin
            @(negedge vga_clk);
            check("drain_we", 32'(mem_we), 32'd1);
            if (j == 0) begin
                check("wr_ready_same_cycle_pop", 32'(wr_ready), 32'd0);
            end
        end
        @(negedge vga_clk);
        check("drain_done", 32'(mem_we), 32'd0);
        check("wr_ready_after_drain", 32'(wr_ready), 32'd1);

        // Earliest memory write is the cycle after acceptance
        tick();
        host_write(14'h0200, 1'b1, 1'b1, acc);
        @(negedge vga_clk);
        check("wr_no_bypass", 32'(mem_we), 32'd0);
        tick();
        wr_valid = 1'b0;
        @(negedge vga_clk);
        check("wr_latency", 32'(mem_we), 32'd1);

`ifdef VRAM_ARB_RDPORT_EN
        // Write then read the same address in one blanking window: write lands first
        tick();
        host_write(14'h0010, 1'b1, 1'b1, acc);
        rd_req  = 1'b1;
        rd_addr = 14'h0010;
        racc    = rd_ready;
        check("rd_accept", 32'(racc), 32'd1);
        if (racc) begin
            exp_rd_q.push_back(ref_mem[14'h0010]);
        end
        @(negedge vga_clk);
        check("t3_idle", 32'(mem_we), 32'd0);
        tick();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        @(negedge vga_clk);
        check("t3_wr_first", 32'(mem_we), 32'd1);
        @(negedge vga_clk);
        check("t3_rd_issue_we", 32'(mem_we), 32'd0);
        check("t3_rd_issue_addr", 32'(mem_addr), 32'h0010);
        @(negedge vga_clk);
        check("t3_rd_valid", 32'(rd_valid), 32'd1);
        @(negedge vga_clk);
        check("t3_rd_valid_one_cycle", 32'(rd_valid), 32'd0);

        // Read granted on the last blanking cycle returns in the first active cycle
        tick();
        drive_disp(1'b0, '0);
        rd_req  = 1'b1;
        rd_addr = 14'h2200;
        racc    = rd_ready;
        if (racc) begin
            exp_rd_q.push_back(ref_mem[14'h2200]);
        end
        @(negedge vga_clk);
        check("t4_no_early_valid", 32'(rd_valid), 32'd0);
        tick();
        rd_req = 1'b0;
        @(negedge vga_clk);
        check("t4_issue_addr", 32'(mem_addr), 32'h2200);
        check("t4_issue_we", 32'(mem_we), 32'd0);
        tick();
        drive_disp(1'b1, 14'h2203);
        @(negedge vga_clk);
        check("t4_rd_valid_in_active", 32'(rd_valid), 32'd1);
        check("t4_rd_data_in_active", 32'(rd_data), 32'd1);
        check("t4_disp_after_rd", 32'(disp_data), 32'd0);
        tick();
        drive_disp(1'b1, 14'h2204);
        @(negedge vga_clk);
        check("t4_rd_valid_drop", 32'(rd_valid), 32'd0);
        check("t4_disp_resume", 32'(disp_data), 32'd1);
        tick();
        drive_disp(1'b0, '0);
`endif

        // Reset with three queued writes and a pending read discards them all
        tick();
        drive_disp(1'b1, 14'h2201);
        host_write(14'h0300, 1'b1, 1'b0, acc);
        check("t5_wr0_acc", 32'(acc), 32'd1);
`ifdef VRAM_ARB_RDPORT_EN
        rd_req  = 1'b1;
        rd_addr = 14'h0300;
        check("t5_rd_acc", 32'(rd_ready), 32'd1);
`endif
        for (int i = 1; i < 3; i++) begin
            tick();
            rd_req = 1'b0;
            drive_disp(1'b1, 14'h2201);
            host_write(14'h0300 + 14'(i), 1'b1, 1'b0, acc);
            check("t5_wr_acc", 32'(acc), 32'd1);
        end
        tick();
        wr_valid = 1'b0;
        rst      = 1'b1;
        drive_disp(1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge vga_clk);
        check("t5_wr_ready_after_rst", 32'(wr_ready), 32'd1);
        check("t5_we_after_rst", 32'(mem_we), 32'd0);
`ifdef VRAM_ARB_RDPORT_EN
        check("t5_rd_ready_after_rst", 32'(rd_ready), 32'd1);
`endif
        repeat (6) tick();

        // FIFO is empty after reset: a new write needs the usual one-cycle latency
        host_write(14'h0400, 1'b1, 1'b1, acc);
        @(negedge vga_clk);
        check("post_rst_no_stale_we", 32'(mem_we), 32'd0);
        tick();
        wr_valid = 1'b0;
        @(negedge vga_clk);
        check("post_rst_write", 32'(mem_we), 32'd1);
        repeat (3) tick();

        @(negedge vga_clk);
        #1;
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("disp_queue_drained", 32'(exp_disp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-ported 1-bit video memory (14-bit address, synchronous read) between the display scan-out path and a host port. Display fetches own every cycle in which the display area is active. Host writes and reads are served only in blanking cycles, through a small write FIFO and a one-deep read slot. Sits between the VGA timing/drawing logic and the memory macro, all in the `vga_clk` domain.

## Interface
- `ADDR_W`, 14, memory address width
- `WFIFO_DEPTH`, 4, host write FIFO entries (power of two, ≥2)
- `vga_clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `disp_active`  in  1  display-area flag for the current cycle's fetch
- `disp_addr`  in  ADDR_W  scan-out fetch address
- `disp_data`  out  1  fetched pixel bit, registered
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  FIFO can accept
- `wr_addr`  in  ADDR_W  host write address
- `wr_data`  in  1  host write bit
- `rd_req`  in  1  host read request (`VRAM_ARB_RDPORT_EN` only)
- `rd_ready`  out  1  read slot free (`VRAM_ARB_RDPORT_EN` only)
- `rd_addr`  in  ADDR_W  host read address (`VRAM_ARB_RDPORT_EN` only)
- `rd_valid`  out  1  one-cycle read-return strobe (`VRAM_ARB_RDPORT_EN` only)
- `rd_data`  out  1  read return bit (`VRAM_ARB_RDPORT_EN` only)
- `mem_addr`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  1  memory write data
- `mem_rdata`  in  1  memory read data, valid one cycle after address

## Operation
- Slot owner each cycle, fixed priority:
  - DISP if `disp_active`
  - else WR if FIFO non-empty
  - else RD if read pending
  - else NONE
- DISP: `mem_addr=disp_addr`, `mem_we=0`.
- WR: head entry drives `mem_addr`/`mem_wdata`, `mem_we=1`, and pops.
- RD: `mem_addr` = latched read address, `mem_we=0`, and clears pending.
- NONE: `mem_addr=disp_addr`, `mem_we=0`.
- Memory-side outputs are combinational from `disp_active` and registered state. They are never X.
- Write FIFO:
  - push when `wr_valid && wr_ready`
  - `wr_ready = !rst && count < WFIFO_DEPTH`; a same-cycle pop does not raise it
  - pointers wrap modulo `WFIFO_DEPTH`; count width is `$clog2(WFIFO_DEPTH)+1`
- Read slot: `rd_ready = !pending`. `rd_req && rd_ready` latches `rd_addr` and sets pending.
- Ordering: RD is never granted while the FIFO is non-empty, so reads see all previously accepted writes.
- Read return: the cycle after the RD grant, `rd_valid=1` and `rd_data=mem_rdata`. This holds even if that cycle is a DISP slot.
- `disp_data` is registered: `mem_rdata` if the previous slot was DISP, else 0.
- Reset values: FIFO empty, pending=0, `disp_data=0`, `rd_valid=0`, `rd_data=0`, `wr_ready=0` and `rd_ready=0` while `rst` is high.
- Reset mid-operation: FIFO contents and any pending or in-flight read are discarded, and no `rd_valid` follows.

## Timing
- Display latency: address at cycle N → `disp_data` valid at N+1. Fixed and never stalled.
- Write: accepted at N; earliest memory write is at N+1 if blanking and the FIFO was empty.
- Read: accepted at N; earliest issue at N+1; `rd_valid` at N+2.
- Throughput in blanking: one host access per cycle. Writes drain before any read.
- During active display, host accesses wait indefinitely. `wr_ready` drops once the FIFO fills.

## Configuration
- `VRAM_ARB_RDPORT_EN` defined:
  - host read slot, RD grant and read-return register exist
  - `rd_*` ports are present
- Not defined:
  - `rd_*` ports are absent
  - arbitration is DISP > WR > NONE only
  - `disp_data` behaviour is unchanged

## Structure
- Package `vram_pkg`:
  - `VRAM_ADDR_W` = 14
  - slot enum `{SLOT_NONE, SLOT_DISP, SLOT_WR, SLOT_RD}`
  - `vram_wr_t` struct {addr, data}
- Sub-module `vram_wr_fifo`: synchronous FIFO with parameterised depth, push/pop/full/empty/count, synchronous active-high reset.
- Top level holds the slot decode, read-slot register, return and display output registers.

## Test plan
- Reset, then `disp_active=1`, `disp_addr` 0x2200..0x2207 with memory preloaded 1,0,1,1,0,0,1,0 → `disp_data` shows the same pattern one cycle later; `mem_we` stays 0.
- Five writes pushed during active display (`WFIFO_DEPTH`=4) → four accepted, `wr_ready`=0 on the fifth; once `disp_active`=0, four consecutive `mem_we` cycles occur in push order.
- Write 0x0010←1 then read 0x0010 issued in the same blanking window → the write hits memory first; `rd_valid` arrives with `rd_data`=1.
- Read issued on the last blanking cycle before `disp_active` rises → `rd_valid` pulses in the first active cycle with correct data; `disp_data` for that cycle is 0, then normal.
- `rst` asserted while the FIFO holds 3 entries and a read is pending → no `mem_we`, no `rd_valid` afterwards; `wr_ready`=1 the cycle after `rst` falls.
- Build without `VRAM_ARB_RDPORT_EN` → write/display scenarios pass unchanged; `mem_we` and `mem_addr` never take an RD slot.
